// File: rtl/change_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : change_pkg
//  Description : Shared types and helpers for the change dispense controller.
//                Coin codes, controller state encoding and the coin-code to
//                value mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package change_pkg;

    // Physical coin codes as presented by the acceptor and the dispenser.
    typedef enum logic [2:0] {
        COIN_NONE = 3'b000,
        COIN_1    = 3'b001,
        COIN_3    = 3'b011,
        COIN_5    = 3'b101
    } coin_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_PLAN    = 3'd2,
        S_DISP1   = 3'd3,
        S_DISP2   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Value of a coin code; any code outside the three legal ones is worth 0,
    // which doubles as the "invalid code" indication.
    function automatic logic [3:0] coin_value(input logic [2:0] code);
        case (code)
            3'b101:  return 4'd5;
            3'b011:  return 4'd3;
            3'b001:  return 4'd1;
            default: return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/change_planner.sv
`default_nettype none
// ============================================================================
//  Module      : change_planner
//  Description : Combinational greedy change planner. Picks up to two coins
//                (5, then 3, then 1) that fit the change amount and are in
//                stock; the second pick sees the inventory left after the
//                first. Reports whatever change could not be covered.
//  Ports       : change_i            change amount to cover
//                inv_p_i/t_i/c_i     current 5/3/1 inventory counts
//                first_o, second_o   planned coins (COIN_NONE if none)
//                rem_o               change left uncovered
//  Revision    : 1.0  initial release
// ============================================================================
module change_planner
    import change_pkg::*;
(
    input  logic [3:0] change_i,
    input  logic [1:0] inv_p_i,
    input  logic [1:0] inv_t_i,
    input  logic [1:0] inv_c_i,
    output coin_t      first_o,
    output coin_t      second_o,
    output logic [3:0] rem_o
);

    function automatic coin_t pick(input logic [3:0] amt,
                                   input logic [1:0] p,
                                   input logic [1:0] t,
                                   input logic [1:0] c);
        if (amt >= 4'd5 && p != 2'd0) return COIN_5;
        if (amt >= 4'd3 && t != 2'd0) return COIN_3;
        if (amt >= 4'd1 && c != 2'd0) return COIN_1;
        return COIN_NONE;
    endfunction

    logic [1:0] p2_d;
    logic [1:0] t2_d;
    logic [1:0] c2_d;
    logic [3:0] after1_d;

    always_comb begin
        first_o  = pick(change_i, inv_p_i, inv_t_i, inv_c_i);
        // The first pick only ever selects a coin with count > 0, so these
        // decrements cannot wrap.
        p2_d     = inv_p_i - ((first_o == COIN_5) ? 2'd1 : 2'd0);
        t2_d     = inv_t_i - ((first_o == COIN_3) ? 2'd1 : 2'd0);
        c2_d     = inv_c_i - ((first_o == COIN_1) ? 2'd1 : 2'd0);
        after1_d = change_i - coin_value(first_o);
        second_o = pick(after1_d, p2_d, t2_d, c2_d);
        rem_o    = after1_d - coin_value(second_o);
    end

endmodule
`default_nettype wire

// File: rtl/change_dispense_controller.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispense_controller
//  Description : Transaction controller: latches a cost, accumulates coins
//                (saturating at 15), plans change in one registered cycle,
//                dispenses up to two coins over valid/ready and reports the
//                outcome with a one-cycle done pulse. Owns the inventory.
//  Options     : CHANGE_CANCEL_EN - when defined, cancel_i in COLLECT aborts
//                the transaction and reports the paid amount as shortfall.
//  Ports       : clock_i/reset_i       clock, synchronous active-high reset
//                start_i/cost_i        begin transaction with a price
//                coin_valid_i/coin_in_i/coin_ready_o  coin acceptor
//                cancel_i              abort request (option above)
//                refill_*              inventory load (IDLE only)
//                disp_valid_o/disp_coin_o/disp_ready_i  dispenser handshake
//                busy_o, paid_o, done_o, exact_o, short_change_o,
//                shortfall_o, cancelled_o, coin_err_o, inv_*_o  status
//  Revision    : 1.0  initial release
// ============================================================================
module change_dispense_controller
    import change_pkg::*;
#(
    parameter logic [1:0] INIT_P = 2'd3,
    parameter logic [1:0] INIT_T = 2'd3,
    parameter logic [1:0] INIT_C = 2'd3
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [3:0] cost_i,
    input  logic       coin_valid_i,
    input  logic [2:0] coin_in_i,
    output logic       coin_ready_o,
    input  logic       cancel_i,
    input  logic       refill_valid_i,
    input  logic [1:0] refill_p_i,
    input  logic [1:0] refill_t_i,
    input  logic [1:0] refill_c_i,
    output logic       disp_valid_o,
    output logic [2:0] disp_coin_o,
    input  logic       disp_ready_i,
    output logic       busy_o,
    output logic [3:0] paid_o,
    output logic       done_o,
    output logic       exact_o,
    output logic       short_change_o,
    output logic [3:0] shortfall_o,
    output logic       cancelled_o,
    output logic       coin_err_o,
    output logic [1:0] inv_p_o,
    output logic [1:0] inv_t_o,
    output logic [1:0] inv_c_o
);

    state_t     state_q;
    logic [3:0] cost_q;
    logic [3:0] paid_q;
    coin_t      first_q;
    coin_t      second_q;
    logic [3:0] rem_q;
    logic       zero_q;
    logic [1:0] inv_p_q, inv_t_q, inv_c_q;
    logic       exact_q, short_q, cancelled_q, coin_err_q;
    logic [3:0] shortfall_q;

    coin_t      plan_first_d;
    coin_t      plan_second_d;
    logic [3:0] plan_rem_d;
    logic [3:0] change_d;
    logic [4:0] paid_sum_d;
    logic [3:0] paid_d;
    logic       coin_ok_d;
    logic       disp_fire_d;
    logic       plan_finish_d;
    logic       disp_finish_d;
    logic       cancel_d;

`ifdef CHANGE_CANCEL_EN
    assign cancel_d = cancel_i;
`else
    logic unused_cancel;
    assign cancel_d      = 1'b0;
    assign unused_cancel = cancel_i;
`endif

    // Only meaningful in PLAN, where paid >= cost is guaranteed.
    assign change_d   = paid_q - cost_q;

    change_planner u_planner (
        .change_i (change_d),
        .inv_p_i  (inv_p_q),
        .inv_t_i  (inv_t_q),
        .inv_c_i  (inv_c_q),
        .first_o  (plan_first_d),
        .second_o (plan_second_d),
        .rem_o    (plan_rem_d)
    );

    assign paid_sum_d = {1'b0, paid_q} + {1'b0, coin_value(coin_in_i)};
    assign paid_d     = paid_sum_d[4] ? 4'hF : paid_sum_d[3:0];
    assign coin_ok_d  = (coin_value(coin_in_i) != 4'd0);

    assign disp_valid_o = (state_q == S_DISP1) || (state_q == S_DISP2);
    assign disp_coin_o  = (state_q == S_DISP1) ? first_q  :
                          (state_q == S_DISP2) ? second_q : COIN_NONE;
    assign disp_fire_d  = disp_valid_o && disp_ready_i;

    // Normal (non-cancel) entries into DONE; status is captured on entry so
    // it is valid alongside the done pulse and holds afterwards.
    assign plan_finish_d = (state_q == S_PLAN) && (plan_first_d == COIN_NONE);
    assign disp_finish_d = disp_fire_d &&
                           ((state_q == S_DISP2) || (second_q == COIN_NONE));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cost_q      <= 4'd0;
            paid_q      <= 4'd0;
            first_q     <= COIN_NONE;
            second_q    <= COIN_NONE;
            rem_q       <= 4'd0;
            zero_q      <= 1'b0;
            inv_p_q     <= INIT_P;
            inv_t_q     <= INIT_T;
            inv_c_q     <= INIT_C;
            exact_q     <= 1'b0;
            short_q     <= 1'b0;
            shortfall_q <= 4'd0;
            cancelled_q <= 1'b0;
            coin_err_q  <= 1'b0;
        end else begin
            coin_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cost_q  <= cost_i;
                        paid_q  <= 4'd0;
                        state_q <= S_COLLECT;
                    end else if (refill_valid_i) begin
                        inv_p_q <= refill_p_i;
                        inv_t_q <= refill_t_i;
                        inv_c_q <= refill_c_i;
                    end
                end
                S_COLLECT: begin
                    if (cancel_d) begin
                        state_q     <= S_DONE;
                        cancelled_q <= 1'b1;
                        exact_q     <= 1'b0;
                        short_q     <= 1'b0;
                        shortfall_q <= paid_q;
                    end else begin
                        // coin_ready is high for all of COLLECT, so a coin
                        // offered in the final COLLECT cycle is still counted.
                        if (coin_valid_i) begin
                            if (coin_ok_d) paid_q     <= paid_d;
                            else           coin_err_q <= 1'b1;
                        end
                        if (paid_q >= cost_q) state_q <= S_PLAN;
                    end
                end
                S_PLAN: begin
                    first_q  <= plan_first_d;
                    second_q <= plan_second_d;
                    rem_q    <= plan_rem_d;
                    zero_q   <= (change_d == 4'd0);
                    state_q  <= (plan_first_d == COIN_NONE) ? S_DONE : S_DISP1;
                end
                S_DISP1: begin
                    if (disp_ready_i)
                        state_q <= (second_q != COIN_NONE) ? S_DISP2 : S_DONE;
                end
                S_DISP2: begin
                    if (disp_ready_i) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (plan_finish_d || disp_finish_d) begin
                exact_q     <= plan_finish_d ? (change_d == 4'd0) : zero_q;
                short_q     <= plan_finish_d ? (plan_rem_d != 4'd0) : (rem_q != 4'd0);
                shortfall_q <= plan_finish_d ? plan_rem_d : rem_q;
                cancelled_q <= 1'b0;
            end

            if (disp_fire_d) begin
                case (disp_coin_o)
                    3'b101:  inv_p_q <= inv_p_q - 2'd1;
                    3'b011:  inv_t_q <= inv_t_q - 2'd1;
                    3'b001:  inv_c_q <= inv_c_q - 2'd1;
                    default: ;
                endcase
            end
        end
    end

    assign coin_ready_o   = (state_q == S_COLLECT);
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign paid_o         = paid_q;
    assign exact_o        = exact_q;
    assign short_change_o = short_q;
    assign shortfall_o    = shortfall_q;
    assign cancelled_o    = cancelled_q;
    assign coin_err_o     = coin_err_q;
    assign inv_p_o        = inv_p_q;
    assign inv_t_o        = inv_t_q;
    assign inv_c_o        = inv_c_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispense_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispense_controller
//  Description : Directed, table-driven bench for change_dispense_controller
//                plus hand-written multi-cycle sequences (done latency,
//                dispenser back-pressure, coin_err, reset mid-dispense,
//                cancel with or without CHANGE_CANCEL_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_change_dispense_controller;

    localparam logic [2:0] C5 = 3'b101;
    localparam logic [2:0] C3 = 3'b011;
    localparam logic [2:0] C1 = 3'b001;
    localparam logic [2:0] CN = 3'b000;

    logic       clk = 1'b0;
    logic       reset, start, coin_valid, cancel, refill_valid, disp_ready;
    logic [3:0] cost;
    logic [2:0] coin_in;
    logic [1:0] refill_p, refill_t, refill_c;
    logic       coin_ready, disp_valid, busy, done, exact, short_change;
    logic       cancelled, coin_err;
    logic [2:0] disp_coin;
    logic [3:0] paid, shortfall;
    logic [1:0] inv_p, inv_t, inv_c;

    change_dispense_controller dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .start_i        (start),
        .cost_i         (cost),
        .coin_valid_i   (coin_valid),
        .coin_in_i      (coin_in),
        .coin_ready_o   (coin_ready),
        .cancel_i       (cancel),
        .refill_valid_i (refill_valid),
        .refill_p_i     (refill_p),
        .refill_t_i     (refill_t),
        .refill_c_i     (refill_c),
        .disp_valid_o   (disp_valid),
        .disp_coin_o    (disp_coin),
        .disp_ready_i   (disp_ready),
        .busy_o         (busy),
        .paid_o         (paid),
        .done_o         (done),
        .exact_o        (exact),
        .short_change_o (short_change),
        .shortfall_o    (shortfall),
        .cancelled_o    (cancelled),
        .coin_err_o     (coin_err),
        .inv_p_o        (inv_p),
        .inv_t_o        (inv_t),
        .inv_c_o        (inv_c)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        bit          rf;
        logic [1:0]  rp, rt, rc;
        logic [3:0]  cost;
        logic [14:0] cs;      // up to five coins, coin k in cs[3k+:3]
        int          paid;
        logic [2:0]  d1, d2;  // expected dispensed coins in order
        bit          ex, sh;
        int          sf;
        int          ip, it, ic;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(bit rf, int rp, int rt, int rc, int cst,
                                logic [2:0] c0, logic [2:0] c1, logic [2:0] c2,
                                logic [2:0] c3, logic [2:0] c4, int pd,
                                logic [2:0] d1, logic [2:0] d2, bit ex, bit sh,
                                int sf, int ip, int it, int ic);
        vec_t v;
        v.rf = rf; v.rp = 2'(rp); v.rt = 2'(rt); v.rc = 2'(rc);
        v.cost = 4'(cst);
        v.cs = {c4, c3, c2, c1, c0};
        v.paid = pd; v.d1 = d1; v.d2 = d2; v.ex = ex; v.sh = sh; v.sf = sf;
        v.ip = ip; v.it = it; v.ic = ic;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [1:0] p, input logic [1:0] t, input logic [1:0] c);
        refill_valid = 1'b1; refill_p = p; refill_t = t; refill_c = c;
        tick();
        refill_valid = 1'b0;
    endtask

    task automatic begin_txn(input logic [3:0] c);
        start = 1'b1; cost = c;
        tick();
        start = 1'b0;
    endtask

    task automatic put_coin(input logic [2:0] c);
        coin_valid = 1'b1; coin_in = c;
        tick();
        coin_valid = 1'b0; coin_in = 3'b000;
    endtask

    // Waits (bounded) for done while recording offered coins; disp_ready is
    // driven by the caller.
    task automatic wait_done(output bit ok, output logic [2:0] g1, output logic [2:0] g2);
        int nd;
        ok = 1'b0; g1 = CN; g2 = CN; nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (disp_valid && disp_ready) begin
                if (nd == 0) g1 = disp_coin;
                else         g2 = disp_coin;
                nd++;
            end
            tick();
        end
        chk("done_seen", int'(ok), 1);
    endtask

    task automatic wait_disp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (disp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("disp_valid_seen", int'(ok), 1);
    endtask

    initial begin
        bit         ok;
        logic [2:0] g1, g2, cc;

        reset = 1'b1; start = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
        refill_valid = 1'b0; disp_ready = 1'b0; cost = 4'd0; coin_in = 3'b000;
        refill_p = 2'd0; refill_t = 2'd0; refill_c = 2'd0;

        //        rf rp rt rc cost  coins               paid d1  d2  ex sh sf  inv
        tbl[0]  = mk(0, 0, 0, 0,  7, C5, C3, CN, CN, CN,  8, C1, CN, 0, 0, 0, 3, 3, 2);
        tbl[1]  = mk(0, 0, 0, 0,  6, C3, C3, CN, CN, CN,  6, CN, CN, 1, 0, 0, 3, 3, 2);
        tbl[2]  = mk(0, 0, 0, 0, 14, C5, C5, C3, C5, CN, 15, C1, CN, 0, 0, 0, 3, 3, 1);
        tbl[3]  = mk(0, 0, 0, 0,  2, C5, CN, CN, CN, CN,  5, C3, CN, 0, 0, 0, 3, 2, 1);
        tbl[4]  = mk(0, 0, 0, 0,  0, CN, CN, CN, CN, CN,  0, CN, CN, 1, 0, 0, 3, 2, 1);
        tbl[5]  = mk(0, 0, 0, 0,  1, C5, CN, CN, CN, CN,  5, C3, C1, 0, 0, 0, 3, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0,  3, C1, C1, C5, CN, CN,  7, C3, CN, 0, 1, 1, 3, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0,  4, C3, C5, CN, CN, CN,  8, CN, CN, 0, 1, 4, 3, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0,  1, C5, CN, CN, CN, CN,  5, C3, CN, 0, 1, 1, 0, 0, 0);
        tbl[9]  = mk(1, 1, 2, 3, 15, C5, C5, C3, C1, C1, 15, CN, CN, 1, 0, 0, 1, 2, 3);
        tbl[10] = mk(0, 0, 0, 0,  9, C5, C3, C3, CN, CN, 11, C1, C1, 0, 0, 0, 1, 2, 1);

        tick(); tick();
        reset = 1'b0;

        chk("rst_busy",       int'(busy), 0);
        chk("rst_coin_ready", int'(coin_ready), 0);
        chk("rst_disp_valid", int'(disp_valid), 0);
        chk("rst_disp_coin",  int'(disp_coin), 0);
        chk("rst_paid",       int'(paid), 0);
        chk("rst_done",       int'(done), 0);
        chk("rst_status",     int'({exact, short_change, cancelled, coin_err}), 0);
        chk("rst_shortfall",  int'(shortfall), 0);
        chk("rst_inv",        int'({inv_p, inv_t, inv_c}), 6'b111111);

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rf) refill(tbl[i].rp, tbl[i].rt, tbl[i].rc);
            begin_txn(tbl[i].cost);
            chk($sformatf("v%0d_coin_ready", i), int'(coin_ready), 1);
            for (int k = 0; k < 5; k++) begin
                cc = tbl[i].cs[3*k +: 3];
                if (cc != CN) put_coin(cc);
            end
            chk($sformatf("v%0d_paid", i), int'(paid), tbl[i].paid);
            disp_ready = 1'b1;
            wait_done(ok, g1, g2);
            disp_ready = 1'b0;
            chk($sformatf("v%0d_disp1", i), int'(g1), int'(tbl[i].d1));
            chk($sformatf("v%0d_disp2", i), int'(g2), int'(tbl[i].d2));
            chk($sformatf("v%0d_exact", i), int'(exact), int'(tbl[i].ex));
            chk($sformatf("v%0d_short", i), int'(short_change), int'(tbl[i].sh));
            chk($sformatf("v%0d_shortfall", i), int'(shortfall), tbl[i].sf);
            chk($sformatf("v%0d_cancelled", i), int'(cancelled), 0);
            chk($sformatf("v%0d_inv", i), int'({inv_p, inv_t, inv_c}),
                (tbl[i].ip << 4) | (tbl[i].it << 2) | tbl[i].ic);
            tick();
            chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
            chk($sformatf("v%0d_idle", i), int'(busy), 0);
        end

        // ---------------- exact payment latency ----------------
        begin_txn(4'd6);
        put_coin(C3);
        put_coin(C3);
        chk("lat_c1_done", int'(done), 0);
        chk("lat_c1_paid", int'(paid), 6);
        tick();
        chk("lat_c2_done", int'(done), 0);
        chk("lat_c2_dv",   int'(disp_valid), 0);
        tick();
        chk("lat_c3_done",  int'(done), 1);
        chk("lat_c3_exact", int'(exact), 1);
        chk("lat_c3_dv",    int'(disp_valid), 0);
        tick();
        chk("lat_hold_done",  int'(done), 0);
        chk("lat_hold_exact", int'(exact), 1);

        // ---------------- dispenser back-pressure ----------------
        refill(2'd0, 2'd1, 2'd0);
        begin_txn(4'd1);
        put_coin(C5);
        disp_ready = 1'b0;
        wait_disp(ok);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_hold%0d_coin", k), int'(disp_coin), int'(C3));
            chk($sformatf("bp_hold%0d_dv", k), int'(disp_valid), 1);
            chk($sformatf("bp_hold%0d_inv_t", k), int'(inv_t), 1);
            tick();
        end
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        chk("bp_done",      int'(done), 1);
        chk("bp_short",     int'(short_change), 1);
        chk("bp_shortfall", int'(shortfall), 1);
        chk("bp_exact",     int'(exact), 0);
        chk("bp_inv_t",     int'(inv_t), 0);
        tick();

        // ---------------- start beats refill; invalid coin ----------------
        refill(2'd3, 2'd3, 2'd3);
        start = 1'b1; cost = 4'd5;
        refill_valid = 1'b1; refill_p = 2'd0; refill_t = 2'd0; refill_c = 2'd0;
        tick();
        start = 1'b0; refill_valid = 1'b0;
        chk("sr_inv",   int'({inv_p, inv_t, inv_c}), 6'b111111);
        chk("sr_busy",  int'(busy), 1);
        put_coin(3'b010);
        chk("err_pulse", int'(coin_err), 1);
        chk("err_paid",  int'(paid), 0);
        tick();
        chk("err_clear", int'(coin_err), 0);
        put_coin(C5);
        chk("err_paid5", int'(paid), 5);
        disp_ready = 1'b1;
        wait_done(ok, g1, g2);
        disp_ready = 1'b0;
        chk("err_exact", int'(exact), 1);
        tick();

        // ---------------- reset during DISP1 ----------------
        refill(2'd0, 2'd0, 2'd1);
        begin_txn(4'd4);
        put_coin(C5);
        disp_ready = 1'b0;
        wait_disp(ok);
        chk("rd_coin", int'(disp_coin), int'(C1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rd_dv",   int'(disp_valid), 0);
        chk("rd_coin0", int'(disp_coin), 0);
        chk("rd_busy", int'(busy), 0);
        chk("rd_done", int'(done), 0);
        chk("rd_paid", int'(paid), 0);
        chk("rd_inv",  int'({inv_p, inv_t, inv_c}), 6'b111111);

        // ---------------- cancel ----------------
        begin_txn(4'd9);
        put_coin(C5);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`ifdef CHANGE_CANCEL_EN
        chk("cx_done",      int'(done), 1);
        chk("cx_cancelled", int'(cancelled), 1);
        chk("cx_shortfall", int'(shortfall), 5);
        chk("cx_dv",        int'(disp_valid), 0);
        chk("cx_inv",       int'({inv_p, inv_t, inv_c}), 6'b111111);
        tick();
        chk("cx_idle", int'(busy), 0);
`else
        chk("cx_ign_done", int'(done), 0);
        chk("cx_ign_busy", int'(coin_ready), 1);
        put_coin(C5);
        chk("cx_ign_paid", int'(paid), 10);
        disp_ready = 1'b1;
        wait_done(ok, g1, g2);
        disp_ready = 1'b0;
        chk("cx_ign_disp",      int'(g1), int'(C1));
        chk("cx_ign_cancelled", int'(cancelled), 0);
        chk("cx_ign_inv_c",     int'(inv_c), 2);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
